// File: rtl/full_hash_des_stream_pkg.sv
// Shared types, constants and the reference hash arithmetic for the
// streaming DES-S-box nibble hash core.
package fhd_pkg;

  // Initial chaining value: H[0] is the low nibble.
  localparam logic [31:0] INIT = 32'h4B71_DF03;

  typedef enum logic [1:0] {ABSORB, ROUND, FINAL, OUT} state_t;

  // DES S5, 64 nibbles, entry {row[1:0], col[3:0]} at nibble index.
  localparam logic [255:0] S5_LUT =
    256'h354A_90F6_D2E1_7C8B_E036_5C9F_87DA_B124_6893_AF05_1D74_C2BE_9E0D_F358_6BA7_14C2;

  // 6-to-4 S-box: row = {x[5], x[0]}, col = x[4:1].
  function automatic logic [3:0] sbox6to4(input logic [5:0] x);
    logic [5:0] idx;
    idx = {x[5], x[0], x[4:1]};
    return S5_LUT[{idx, 2'b00} +: 4];
  endfunction

  // Byte spreading used when absorbing a message byte.
  function automatic logic [5:0] compress_m6(input logic [7:0] m);
    return {m[3] ^ m[2], m[1], m[0], m[7], m[6], m[5] ^ m[4]};
  endfunction

  // Byte spreading used for each length byte during finalisation.
  function automatic logic [5:0] len_to_c6(input logic [7:0] b);
    return {b[7] ^ b[1], b[3], b[2], b[5] ^ b[0], b[4], b[6]};
  endfunction

  // 4-bit rotate left by 0..3.
  function automatic logic [3:0] rotl4(input logic [3:0] x, input logic [1:0] k);
    logic [7:0] t;
    t = {x, x} << k;
    return t[7:4];
  endfunction

  // One compression round: nibbles shift down by one, mix in s, rotate by i/2.
  function automatic logic [31:0] hash_round(input logic [31:0] h, input logic [3:0] s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = rotl4(h[4*((i+1)%8) +: 4] ^ s, 2'(i/2));
    end
    return r;
  endfunction

  // Final mix: nibble i takes the S-box of length byte i instead of a common s.
  function automatic logic [31:0] finalize(input logic [31:0] h, input logic [63:0] len);
    logic [31:0] d;
    logic [3:0]  sk;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      sk = sbox6to4(len_to_c6(len[8*k +: 8]));
      d[4*k +: 4] = rotl4(h[4*((k+1)%8) +: 4] ^ sk, 2'(k/2));
    end
    return d;
  endfunction

endpackage

// File: rtl/full_hash_des_stream_if.sv
// Message-in / digest-out stream bundle of the hash core.
interface full_hash_des_stream_if;
  logic        msg_valid;
  logic        msg_ready;
  logic [7:0]  msg_data;
  logic        msg_last;
  logic        msg_empty;
  logic        dig_valid;
  logic        dig_ready;
  logic [31:0] digest;

  // Byte source and digest consumer side.
  modport master (
    output msg_valid, msg_data, msg_last, msg_empty, dig_ready,
    input  msg_ready, dig_valid, digest
  );

  // Hash core side.
  modport slave (
    input  msg_valid, msg_data, msg_last, msg_empty, dig_ready,
    output msg_ready, dig_valid, digest
  );
endinterface

// File: rtl/full_hash_des_stream_round_unit.sv
// Combinational chain of ROUNDS_PER_CYCLE hash rounds sharing one s value.
module fhd_round_unit
  import fhd_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 4
) (
  input  logic [31:0] h_in,
  input  logic [3:0]  s,
  output logic [31:0] h_out
);

  // Each stage owns its own net so the chain is not one self-feeding array.
  for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
    logic [31:0] h_stage;
    if (gi == 0) begin : g_first
      assign h_stage = hash_round(h_in, s);
    end else begin : g_next
      assign h_stage = hash_round(g_round[gi-1].h_stage, s);
    end
  end

  assign h_out = g_round[ROUNDS_PER_CYCLE-1].h_stage;

endmodule

// File: rtl/full_hash_des_stream.sv
// Streaming DES-S-box nibble hash: absorbs bytes, counts length, emits a
// 32-bit digest with backpressure.
module full_hash_des_stream
  import fhd_pkg::*;
#(
  parameter int ROUNDS           = 4,
  parameter int ROUNDS_PER_CYCLE = 4,
  parameter int LEN_W            = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  full_hash_des_stream_if.slave  bus,
  output logic                   busy
);

  localparam int NCYC   = (ROUNDS_PER_CYCLE > 0) ? ROUNDS / ROUNDS_PER_CYCLE : 1;
  localparam int RCNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(NCYC - 1);

  if (ROUNDS < 1 || ROUNDS_PER_CYCLE < 1 || (ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_rounds
    $error("full_hash_des_stream: ROUNDS_PER_CYCLE must be >=1 and divide ROUNDS (>=1)");
  end
  if (LEN_W < 1 || LEN_W > 64) begin : g_bad_len
    $error("full_hash_des_stream: LEN_W must be in 1..64");
  end

  state_t            state_reg, state_next;
  logic [31:0]       h_reg, h_next;
  logic [3:0]        s_reg, s_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic              last_reg, last_next;
  logic [RCNT_W-1:0] rcnt_reg, rcnt_next;
  logic              dig_valid_reg, dig_valid_next;
  logic [31:0]       digest_reg, digest_next;

  logic              msg_ready_int;
  logic [31:0]       h_round;
  logic [63:0]       len64;

  fhd_round_unit #(.ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)) u_round (
    .h_in  (h_reg),
    .s     (s_reg),
    .h_out (h_round)
  );

  assign msg_ready_int = (state_reg == ABSORB) && !clear;
  assign len64         = 64'(len_reg);

  assign bus.msg_ready = rst_n && msg_ready_int;
  assign bus.dig_valid = dig_valid_reg;
  assign bus.digest    = digest_reg;
  assign busy          = (state_reg != ABSORB) || (len_reg != '0);

  // Next-state and datapath updates; clear has the last word over everything.
  always_comb begin
    state_next     = state_reg;
    h_next         = h_reg;
    s_next         = s_reg;
    len_next       = len_reg;
    last_next      = last_reg;
    rcnt_next      = rcnt_reg;
    dig_valid_next = dig_valid_reg;
    digest_next    = digest_reg;

    case (state_reg)
      ABSORB: begin
        if (bus.msg_valid && msg_ready_int) begin
          if (!bus.msg_empty) begin
            s_next     = sbox6to4(compress_m6(bus.msg_data));
            len_next   = len_reg + LEN_W'(1);
            last_next  = bus.msg_last;
            rcnt_next  = '0;
            state_next = ROUND;
          end else if (bus.msg_last) begin
            state_next = FINAL;
          end
        end
      end
      ROUND: begin
        h_next    = h_round;
        rcnt_next = rcnt_reg + RCNT_W'(1);
        if (rcnt_reg == RCNT_LAST) begin
          state_next = last_reg ? FINAL : ABSORB;
        end
      end
      FINAL: begin
        digest_next    = finalize(h_reg, len64);
        dig_valid_next = 1'b1;
        state_next     = OUT;
      end
      OUT: begin
        if (bus.dig_ready) begin
          dig_valid_next = 1'b0;
          h_next         = INIT;
          len_next       = '0;
          state_next     = ABSORB;
        end
      end
      default: state_next = ABSORB;
    endcase

    if (clear) begin
      state_next     = ABSORB;
      h_next         = INIT;
      len_next       = '0;
      dig_valid_next = 1'b0;
    end
  end

  // State and datapath registers, cleared immediately by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ABSORB;
      h_reg         <= INIT;
      s_reg         <= '0;
      len_reg       <= '0;
      last_reg      <= 1'b0;
      rcnt_reg      <= '0;
      dig_valid_reg <= 1'b0;
      digest_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      h_reg         <= h_next;
      s_reg         <= s_next;
      len_reg       <= len_next;
      last_reg      <= last_next;
      rcnt_reg      <= rcnt_next;
      dig_valid_reg <= dig_valid_next;
      digest_reg    <= digest_next;
    end
  end

endmodule

// File: tb/tb_full_hash_des_stream.sv
// Bench for full_hash_des_stream: two instances (4 and 1 rounds per cycle),
// a nibble-level model of the hash, and directed plus randomised messages.
module tb_full_hash_des_stream;

  localparam int ROUNDS = 4;
  localparam logic [31:0] TB_INIT   = 32'h4B71_DF03;
  localparam logic [31:0] DIG_ZERO  = 32'h8365_6FD2;
  localparam logic [31:0] DIG_BYTE0 = 32'h561B_BAAF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tb_clear = 1'b0;
  logic tb_valid = 1'b0;
  logic [7:0] tb_data = '0;
  logic tb_last = 1'b0;
  logic tb_empty = 1'b0;
  logic tb_dig_ready = 1'b0;
  logic sel = 1'b0;
  logic busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  full_hash_des_stream_if ifa ();
  full_hash_des_stream_if ifb ();

  assign ifa.msg_valid = tb_valid & ~sel;
  assign ifb.msg_valid = tb_valid & sel;
  assign ifa.msg_data  = tb_data;
  assign ifb.msg_data  = tb_data;
  assign ifa.msg_last  = tb_last;
  assign ifb.msg_last  = tb_last;
  assign ifa.msg_empty = tb_empty;
  assign ifb.msg_empty = tb_empty;
  assign ifa.dig_ready = tb_dig_ready & ~sel;
  assign ifb.dig_ready = tb_dig_ready & sel;

  full_hash_des_stream #(.ROUNDS(ROUNDS), .ROUNDS_PER_CYCLE(4), .LEN_W(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(tb_clear), .bus(ifa), .busy(busy_a));
  full_hash_des_stream #(.ROUNDS(ROUNDS), .ROUNDS_PER_CYCLE(1), .LEN_W(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(tb_clear), .bus(ifb), .busy(busy_b));

  logic        cur_ready, cur_dig_valid, cur_busy;
  logic [31:0] cur_digest;
  assign cur_ready     = sel ? ifb.msg_ready : ifa.msg_ready;
  assign cur_dig_valid = sel ? ifb.dig_valid : ifa.dig_valid;
  assign cur_digest    = sel ? ifb.digest    : ifa.digest;
  assign cur_busy      = sel ? busy_b        : busy_a;

  // ---------------- behavioural model ----------------
  int S5 [4][16] = '{
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9},
    '{14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6},
    '{ 4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14},
    '{11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3}};

  int              mh [8];
  longint unsigned mlen;
  logic [31:0]     exp_q [$];

  function automatic int bt(int v, int n);
    return (v >> n) & 1;
  endfunction

  function automatic int sb(int x6);
    int row, col;
    row = bt(x6, 5) * 2 + bt(x6, 0);
    col = (x6 >> 1) & 15;
    return S5[row][col];
  endfunction

  function automatic int rot(int x, int k);
    return ((x << k) | (x >> (4 - k))) & 15;
  endfunction

  function automatic int m6(int b);
    return ((bt(b,3) ^ bt(b,2)) << 5) | (bt(b,1) << 4) | (bt(b,0) << 3) |
           (bt(b,7) << 2) | (bt(b,6) << 1) | (bt(b,5) ^ bt(b,4));
  endfunction

  function automatic int c6(int b);
    return ((bt(b,7) ^ bt(b,1)) << 5) | (bt(b,3) << 4) | (bt(b,2) << 3) |
           ((bt(b,5) ^ bt(b,0)) << 2) | (bt(b,4) << 1) | bt(b,6);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mh[i] = int'((TB_INIT >> (4*i)) & 32'hF);
    mlen = 0;
  endtask

  task automatic model_round(input int s);
    int t [8];
    for (int i = 0; i < 8; i++) t[i] = rot(mh[(i+1)%8] ^ s, i/2);
    mh = t;
  endtask

  function automatic logic [31:0] model_final();
    logic [31:0] d;
    int b, sk;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      b  = int'((mlen >> (8*k)) & 64'hFF);
      sk = sb(c6(b));
      d  = d | (32'(rot(mh[(k+1)%8] ^ sk, k/2)) << (4*k));
    end
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare process: outputs are stable at negedge; inputs for the next edge are too.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_msg_ready", cur_ready, 0);
      chk("reset_dig_valid", cur_dig_valid, 0);
      chk("reset_digest", cur_digest, 0);
      chk("reset_busy", cur_busy, 0);
      model_reset();
      exp_q.delete();
    end else begin
      if (cur_dig_valid) begin
        if (exp_q.size() == 0) chk("dig_valid_without_message", cur_dig_valid, 0);
        else                   chk("digest_vs_model", cur_digest, exp_q[0]);
      end
      if (tb_clear) begin
        model_reset();
        exp_q.delete();
      end else begin
        if (cur_dig_valid && tb_dig_ready) begin
          void'(exp_q.pop_front());
          model_reset();
        end
        if (tb_valid && cur_ready) begin
          if (!tb_empty) begin
            for (int r = 0; r < ROUNDS; r++) model_round(sb(m6(int'(tb_data))));
            mlen++;
          end
          if (tb_last) exp_q.push_back(model_final());
        end
      end
    end
  end

  // ---------------- stimulus helpers (all drives at posedge + 1) ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic e);
    logic hs;
    hs = 1'b0;
    tb_valid = 1'b1; tb_data = d; tb_last = l; tb_empty = e;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      hs = cur_ready;
      step();
      if (hs) break;
    end
    chk("msg_handshake", hs, 1);
    tb_valid = 1'b0; tb_last = 1'b0; tb_empty = 1'b0;
  endtask

  // lat counts cycles from the handshake cycle to the first cycle with dig_valid.
  task automatic wait_digest(output int lat, output int rdy_hi);
    logic seen;
    seen = 1'b0; lat = 1; rdy_hi = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (cur_dig_valid) begin seen = 1'b1; break; end
      if (cur_ready) rdy_hi++;
      lat++;
    end
    chk("dig_valid_seen", seen, 1);
    step();
  endtask

  task automatic take_digest();
    $display("[TB] dut %0d digest %08h", sel, cur_digest);
    tb_dig_ready = 1'b1;
    step();
    tb_dig_ready = 1'b0;
    @(negedge clk);
    chk("dig_valid_after_take", cur_dig_valid, 0);
    chk("msg_ready_after_take", cur_ready, 1);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rdy_hi, nb;
    model_reset();

    // Reset state.
    repeat (3) step();
    chk("rst_msg_ready_low", cur_ready, 0);
    chk("rst_digest_zero", cur_digest, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cur_ready, 1);
    chk("post_rst_busy", cur_busy, 0);
    chk("post_rst_dig_valid", cur_dig_valid, 0);
    step();

    // Zero-length message.
    send_beat(8'h00, 1'b1, 1'b1);
    wait_digest(lat, rdy_hi);
    chk("zero_len_latency", lat, 2);
    chk("zero_len_digest", cur_digest, DIG_ZERO);
    chk("model_zero_len", exp_q[0], DIG_ZERO);
    take_digest();

    // One byte 0x00, then backpressure.
    send_beat(8'h00, 1'b1, 1'b0);
    wait_digest(lat, rdy_hi);
    chk("byte0_latency", lat, 3);
    chk("byte0_digest", cur_digest, DIG_BYTE0);
    chk("model_byte0", exp_q[0], DIG_BYTE0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_dig_valid", cur_dig_valid, 1);
      chk("bp_digest", cur_digest, DIG_BYTE0);
      chk("bp_msg_ready", cur_ready, 0);
      chk("bp_busy", cur_busy, 1);
      step();
    end
    take_digest();
    send_beat(8'h00, 1'b1, 1'b1);
    wait_digest(lat, rdy_hi);
    chk("reinit_zero_len_digest", cur_digest, DIG_ZERO);
    take_digest();

    // One round per cycle instance.
    sel = 1'b1;
    step();
    send_beat(8'h00, 1'b1, 1'b0);
    wait_digest(lat, rdy_hi);
    chk("rpc1_latency", lat, 6);
    chk("rpc1_ready_low_while_busy", rdy_hi, 0);
    chk("rpc1_digest", cur_digest, DIG_BYTE0);
    @(negedge clk);
    chk("rpc1_ready_low_in_out", cur_ready, 0);
    step();
    take_digest();
    sel = 1'b0;
    step();

    // Clear during ROUND after three bytes.
    send_beat(8'h12, 1'b0, 1'b0);
    send_beat(8'h34, 1'b0, 1'b0);
    send_beat(8'h56, 1'b0, 1'b0);
    tb_clear = 1'b1;
    step();
    tb_clear = 1'b0;
    @(negedge clk);
    chk("clear_busy", cur_busy, 0);
    step();
    send_beat(8'h00, 1'b1, 1'b0);
    wait_digest(lat, rdy_hi);
    chk("after_clear_digest", cur_digest, DIG_BYTE0);
    take_digest();

    // Clear with a simultaneous beat: beat must not be consumed.
    tb_valid = 1'b1; tb_data = 8'hAA; tb_last = 1'b1; tb_empty = 1'b0; tb_clear = 1'b1;
    @(negedge clk);
    chk("clear_blocks_ready", cur_ready, 0);
    step();
    tb_valid = 1'b0; tb_last = 1'b0; tb_clear = 1'b0;
    @(negedge clk);
    chk("clear_beat_dropped_busy", cur_busy, 0);
    chk("clear_beat_no_digest", cur_dig_valid, 0);
    step();
    send_beat(8'h00, 1'b1, 1'b1);
    wait_digest(lat, rdy_hi);
    chk("clear_beat_dropped_digest", cur_digest, DIG_ZERO);

    // Clear beats a simultaneous digest handshake; digest value is kept.
    tb_clear = 1'b1; tb_dig_ready = 1'b1;
    step();
    tb_clear = 1'b0; tb_dig_ready = 1'b0;
    @(negedge clk);
    chk("clear_out_dig_valid", cur_dig_valid, 0);
    chk("clear_out_digest_kept", cur_digest, DIG_ZERO);
    chk("clear_out_ready", cur_ready, 1);
    step();

    // Asynchronous reset during ROUND on the slow instance.
    sel = 1'b1;
    step();
    send_beat(8'h77, 1'b0, 1'b0);
    send_beat(8'h01, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", cur_ready, 0);
    chk("async_rst_busy", cur_busy, 0);
    chk("async_rst_dig_valid", cur_dig_valid, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    send_beat(8'h00, 1'b1, 1'b1);
    wait_digest(lat, rdy_hi);
    chk("after_rst_digest", cur_digest, DIG_ZERO);
    take_digest();

    // Random messages with gaps, empty filler beats and stray dig_ready.
    for (int m = 0; m < 12; m++) begin
      logic end_empty;
      sel = m[0];
      step();
      nb = $urandom_range(0, 5);
      for (int b = 0; b < nb; b++) begin
        tb_dig_ready = ($urandom_range(0, 3) == 0);
        repeat ($urandom_range(0, 2)) step();
        tb_dig_ready = 1'b0;
        if ($urandom_range(0, 3) == 0) send_beat(8'($urandom), 1'b0, 1'b1);
        send_beat(8'($urandom), 1'b0, 1'b0);
      end
      end_empty = ($urandom_range(0, 1) == 1);
      send_beat(8'($urandom), 1'b1, end_empty);
      wait_digest(lat, rdy_hi);
      chk("rand_latency", lat, end_empty ? 2 : (sel ? 6 : 3));
      repeat ($urandom_range(0, 3)) step();
      take_digest();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
